// File: rtl/mac_pkg.sv
// Types and defaults shared by the MAC-cluster operand feeder and its testbench.
package mac_pkg;

  localparam int MAC_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } feeder_state_e;

  typedef struct packed {
    logic [MAC_DATA_WIDTH-1:0] m1_a;
    logic [MAC_DATA_WIDTH-1:0] m1_b;
    logic [MAC_DATA_WIDTH-1:0] m2_a;
    logic [MAC_DATA_WIDTH-1:0] m2_b;
  } mac_operands_t;

endpackage

// File: rtl/op_skid_buf.sv
// Two-entry FIFO holding packed operand beats plus their last flag.
module op_skid_buf #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;

  assign head  = mem[rd_ptr];
  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);

  // Storage is left unreset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mac_operand_feeder.sv
// Buffers operand beats, issues them to the MAC cluster and signals vector results.
// Optional build macro ZERO_SKIP_EN: skip issuing beats whose two products are both zero.
module mac_operand_feeder
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH  = MAC_DATA_WIDTH,
  parameter int MAC_LATENCY = 2,
  parameter int MAX_BEATS   = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [4*DATA_WIDTH-1:0]       in_data,
  input  logic                          in_last,
  input  logic                          cluster_stall,
  output logic                          ebl,
  output logic                          acc_clr,
  output logic [DATA_WIDTH-1:0]         m1_a,
  output logic [DATA_WIDTH-1:0]         m1_b,
  output logic [DATA_WIDTH-1:0]         m2_a,
  output logic [DATA_WIDTH-1:0]         m2_b,
  output logic                          res_valid,
  output logic                          busy,
  output logic [$clog2(MAX_BEATS):0]    beat_cnt,
  output logic                          err_ovf
);

  localparam int CNT_W = $clog2(MAX_BEATS) + 1;
  localparam int DRN_W = $clog2(MAC_LATENCY + 1);
  localparam int BUF_W = 4*DATA_WIDTH + 1;

  feeder_state_e           state;
  logic [DRN_W-1:0]        drain_cnt;
  logic                    buf_empty;
  logic                    buf_full;
  logic                    push;
  logic                    pop;
  logic [BUF_W-1:0]        head;
  logic [4*DATA_WIDTH-1:0] head_ops;
  logic                    head_last;
  logic [CNT_W-1:0]        next_cnt;
  logic                    end_vec;
  logic                    skip_beat;

  op_skid_buf #(.WIDTH(BUF_W)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({in_data, in_last}),
    .pop       (pop),
    .head      (head),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  assign head_ops  = head[BUF_W-1:1];
  assign head_last = head[0];

  assign in_ready = !buf_full && (state != DRAIN);
  assign push     = in_valid && in_ready;
  assign pop      = !buf_empty && !cluster_stall && (state != DRAIN);
  assign busy     = (state != IDLE) || !buf_empty;

  // A vector also ends when MAX_BEATS is reached without a last flag.
  assign next_cnt = (state == IDLE) ? CNT_W'(1) : beat_cnt + CNT_W'(1);
  assign end_vec  = head_last || (next_cnt == CNT_W'(MAX_BEATS));

`ifdef ZERO_SKIP_EN
  logic both_zero;
  assign both_zero = ((head_ops[4*DATA_WIDTH-1:3*DATA_WIDTH] == '0) ||
                      (head_ops[3*DATA_WIDTH-1:2*DATA_WIDTH] == '0)) &&
                     ((head_ops[2*DATA_WIDTH-1:DATA_WIDTH] == '0) ||
                      (head_ops[DATA_WIDTH-1:0] == '0));
  // The accumulator-clearing beat must always reach the cluster.
  assign skip_beat = both_zero && (state != IDLE);
`else
  assign skip_beat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      ebl       <= 1'b0;
      acc_clr   <= 1'b0;
      m1_a      <= '0;
      m1_b      <= '0;
      m2_a      <= '0;
      m2_b      <= '0;
      res_valid <= 1'b0;
      beat_cnt  <= '0;
      err_ovf   <= 1'b0;
    end else begin
      ebl       <= 1'b0;
      acc_clr   <= 1'b0;
      res_valid <= 1'b0;
      err_ovf   <= 1'b0;
      case (state)
        IDLE, RUN: begin
          if (pop) begin
            ebl      <= !skip_beat;
            acc_clr  <= (state == IDLE);
            beat_cnt <= next_cnt;
            if (!skip_beat) begin
              {m1_a, m1_b, m2_a, m2_b} <= head_ops;
            end
            if (end_vec) begin
              state     <= DRAIN;
              drain_cnt <= DRN_W'(MAC_LATENCY);
              err_ovf   <= !head_last;
            end else begin
              state <= RUN;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            res_valid <= 1'b1;
            beat_cnt  <= '0;
            state     <= IDLE;
          end else begin
            drain_cnt <= drain_cnt - DRN_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed testbench for mac_operand_feeder: vector table plus overflow and reset sequences.
// Build with ZERO_SKIP_EN defined to exercise the zero-skip expectations.
module tb_mac_operand_feeder;
  import mac_pkg::*;

`ifdef ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        cluster_stall;
  logic        ebl;
  logic        acc_clr;
  logic [7:0]  m1_a, m1_b, m2_a, m2_b;
  logic        res_valid;
  logic        busy;
  logic [6:0]  beat_cnt;
  logic        err_ovf;
  logic [31:0] ops_now;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic          valid;
    mac_operands_t data;
    logic          last;
    logic          stall;
    logic          e_ebl;
    logic          e_acc;
    mac_operands_t e_ops;
    logic          e_res;
    int            e_cnt;
    logic          e_rdy;
    logic          e_busy;
  } vec_t;

  vec_t tbl[$];

  mac_operand_feeder #(.DATA_WIDTH(8), .MAC_LATENCY(2), .MAX_BEATS(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .cluster_stall (cluster_stall),
    .ebl           (ebl),
    .acc_clr       (acc_clr),
    .m1_a          (m1_a),
    .m1_b          (m1_b),
    .m2_a          (m2_a),
    .m2_b          (m2_b),
    .res_valid     (res_valid),
    .busy          (busy),
    .beat_cnt      (beat_cnt),
    .err_ovf       (err_ovf)
  );

  assign ops_now = {m1_a, m1_b, m2_a, m2_b};

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic mac_operands_t mk(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
    mac_operands_t r;
    r = {a, b, c, d};
    return r;
  endfunction

  function automatic mac_operands_t kk(input int k);
    return mk(8'(k), 8'(k), 8'(k), 8'(k));
  endfunction

  function automatic mac_operands_t dd(input int k);
    return mk(8'(16 + k), 8'(32 + k), 8'(48 + k), 8'(64 + k));
  endfunction

  function automatic mac_operands_t bd(input int k);
    return mk(8'(k), 8'(k) ^ 8'hFF, 8'(k + 1), 8'h5A);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add_row(input logic v, input mac_operands_t d, input logic l, input logic s,
                         input logic e_ebl, input logic e_acc, input mac_operands_t e_ops,
                         input logic e_res, input int e_cnt, input logic e_rdy, input logic e_busy);
    vec_t r;
    r.valid = v;     r.data  = d;     r.last  = l;     r.stall = s;
    r.e_ebl = e_ebl; r.e_acc = e_acc; r.e_ops = e_ops; r.e_res = e_res;
    r.e_cnt = e_cnt; r.e_rdy = e_rdy; r.e_busy = e_busy;
    tbl.push_back(r);
  endtask

  task automatic applyStimulus(input vec_t r, input int idx);
    in_valid      = r.valid;
    in_data       = r.data;
    in_last       = r.last;
    cluster_stall = r.stall;
    tick();
    checkOutput($sformatf("row%0d ebl", idx),       32'(ebl),       32'(r.e_ebl));
    checkOutput($sformatf("row%0d acc_clr", idx),   32'(acc_clr),   32'(r.e_acc));
    checkOutput($sformatf("row%0d operands", idx),  ops_now,        r.e_ops);
    checkOutput($sformatf("row%0d res_valid", idx), 32'(res_valid), 32'(r.e_res));
    checkOutput($sformatf("row%0d beat_cnt", idx),  32'(beat_cnt),  32'(r.e_cnt));
    checkOutput($sformatf("row%0d in_ready", idx),  32'(in_ready),  32'(r.e_rdy));
    checkOutput($sformatf("row%0d busy", idx),      32'(busy),      32'(r.e_busy));
    checkOutput($sformatf("row%0d err_ovf", idx),   32'(err_ovf),   32'(0));
  endtask

  task automatic wait_res(input string name, input int exp_cycles);
    int n;
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput(name, 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    int beat_idx, issued, ovf_seen, res_seen, ovf_cyc;
    logic rdy_b;

    // 4-beat vector, no stall
    add_row(1, kk(1), 0, 0,  0, 0, kk(0), 0, 0, 1, 1);
    add_row(1, kk(2), 0, 0,  1, 1, kk(1), 0, 1, 1, 1);
    add_row(1, kk(3), 0, 0,  1, 0, kk(2), 0, 2, 1, 1);
    add_row(1, kk(4), 1, 0,  1, 0, kk(3), 0, 3, 1, 1);
    add_row(0, kk(0), 0, 0,  1, 0, kk(4), 0, 4, 0, 1);
    add_row(0, kk(0), 0, 0,  0, 0, kk(4), 0, 4, 0, 1);
    add_row(0, kk(0), 0, 0,  0, 0, kk(4), 0, 4, 0, 1);
    add_row(0, kk(0), 0, 0,  0, 0, kk(4), 1, 0, 1, 0);
    add_row(0, kk(0), 0, 0,  0, 0, kk(4), 0, 0, 1, 0);
    // 8-beat vector with a one-cycle cluster stall filling the buffer
    add_row(1, dd(1), 0, 0,  0, 0, kk(4), 0, 0, 1, 1);
    add_row(1, dd(2), 0, 0,  1, 1, dd(1), 0, 1, 1, 1);
    add_row(1, dd(3), 0, 1,  0, 0, dd(1), 0, 1, 0, 1);
    add_row(1, dd(4), 0, 0,  1, 0, dd(2), 0, 2, 1, 1);
    add_row(1, dd(4), 0, 0,  1, 0, dd(3), 0, 3, 1, 1);
    add_row(1, dd(5), 0, 0,  1, 0, dd(4), 0, 4, 1, 1);
    add_row(1, dd(6), 0, 0,  1, 0, dd(5), 0, 5, 1, 1);
    add_row(1, dd(7), 0, 0,  1, 0, dd(6), 0, 6, 1, 1);
    add_row(1, dd(8), 1, 0,  1, 0, dd(7), 0, 7, 1, 1);
    add_row(0, kk(0), 0, 0,  1, 0, dd(8), 0, 8, 0, 1);
    add_row(0, kk(0), 0, 0,  0, 0, dd(8), 0, 8, 0, 1);
    add_row(0, kk(0), 0, 0,  0, 0, dd(8), 0, 8, 0, 1);
    add_row(0, kk(0), 0, 0,  0, 0, dd(8), 1, 0, 1, 0);
    // back-to-back vectors, second one offered during DRAIN
    add_row(1, mk(1, 2, 3, 4),     0, 0,  0, 0, dd(8),              0, 0, 1, 1);
    add_row(1, mk(5, 6, 7, 8),     1, 0,  1, 1, mk(1, 2, 3, 4),     0, 1, 1, 1);
    add_row(1, mk(9, 10, 11, 12),  0, 0,  1, 0, mk(5, 6, 7, 8),     0, 2, 0, 1);
    add_row(1, mk(13, 14, 15, 16), 1, 0,  0, 0, mk(5, 6, 7, 8),     0, 2, 0, 1);
    add_row(1, mk(13, 14, 15, 16), 1, 0,  0, 0, mk(5, 6, 7, 8),     0, 2, 0, 1);
    add_row(1, mk(13, 14, 15, 16), 1, 0,  0, 0, mk(5, 6, 7, 8),     1, 0, 1, 1);
    add_row(1, mk(13, 14, 15, 16), 1, 0,  1, 1, mk(9, 10, 11, 12),  0, 1, 1, 1);
    add_row(0, kk(0), 0, 0,  1, 0, mk(13, 14, 15, 16), 0, 2, 0, 1);
    add_row(0, kk(0), 0, 0,  0, 0, mk(13, 14, 15, 16), 0, 2, 0, 1);
    add_row(0, kk(0), 0, 0,  0, 0, mk(13, 14, 15, 16), 0, 2, 0, 1);
    add_row(0, kk(0), 0, 0,  0, 0, mk(13, 14, 15, 16), 1, 0, 1, 0);
    // zero-product beats: skipped only when ZERO_SKIP_EN is built in
    add_row(1, mk(0, 1, 0, 1), 0, 0,  0, 0, mk(13, 14, 15, 16), 0, 0, 1, 1);
    add_row(1, mk(0, 5, 7, 0), 0, 0,  1, 1, mk(0, 1, 0, 1), 0, 1, 1, 1);
    add_row(1, mk(3, 0, 0, 9), 0, 0,  !ZS, 0, ZS ? mk(0, 1, 0, 1) : mk(0, 5, 7, 0), 0, 2, 1, 1);
    add_row(1, mk(1, 2, 3, 4), 1, 0,  !ZS, 0, ZS ? mk(0, 1, 0, 1) : mk(3, 0, 0, 9), 0, 3, 1, 1);
    add_row(0, kk(0), 0, 0,  1, 0, mk(1, 2, 3, 4), 0, 4, 0, 1);
    add_row(0, kk(0), 0, 0,  0, 0, mk(1, 2, 3, 4), 0, 4, 0, 1);
    add_row(0, kk(0), 0, 0,  0, 0, mk(1, 2, 3, 4), 0, 4, 0, 1);
    add_row(0, kk(0), 0, 0,  0, 0, mk(1, 2, 3, 4), 1, 0, 1, 0);
    add_row(1, kk(2), 0, 0,  0, 0, mk(1, 2, 3, 4), 0, 0, 1, 1);
    add_row(1, kk(0), 1, 0,  1, 1, kk(2), 0, 1, 1, 1);
    add_row(0, kk(0), 0, 0,  !ZS, 0, ZS ? kk(2) : kk(0), 0, 2, 0, 1);
    add_row(0, kk(0), 0, 0,  0, 0, ZS ? kk(2) : kk(0), 0, 2, 0, 1);
    add_row(0, kk(0), 0, 0,  0, 0, ZS ? kk(2) : kk(0), 0, 2, 0, 1);
    add_row(0, kk(0), 0, 0,  0, 0, ZS ? kk(2) : kk(0), 1, 0, 1, 0);

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; cluster_stall = 1'b0;
    tick();
    tick();
    $display("[TB] checking reset state");
    checkOutput("reset ebl",       32'(ebl),       32'(0));
    checkOutput("reset acc_clr",   32'(acc_clr),   32'(0));
    checkOutput("reset operands",  ops_now,        32'(0));
    checkOutput("reset res_valid", 32'(res_valid), 32'(0));
    checkOutput("reset beat_cnt",  32'(beat_cnt),  32'(0));
    checkOutput("reset in_ready",  32'(in_ready),  32'(1));
    checkOutput("reset busy",      32'(busy),      32'(0));
    checkOutput("reset err_ovf",   32'(err_ovf),   32'(0));
    rst = 1'b0;

    $display("[TB] running %0d table rows", tbl.size());
    foreach (tbl[i]) applyStimulus(tbl[i], i);

    // 65 beats without an early last: overflow closes the first 64
    $display("[TB] overflow sequence");
    beat_idx = 1; issued = 0; ovf_seen = 0; res_seen = 0; ovf_cyc = 0;
    for (int cyc = 0; cyc < 400 && res_seen < 2; cyc++) begin
      in_valid = (beat_idx <= 65);
      in_data  = bd(beat_idx);
      in_last  = (beat_idx == 65);
      rdy_b    = in_ready;
      tick();
      if (in_valid && rdy_b) beat_idx++;
      if (ebl) begin
        issued++;
        checkOutput($sformatf("ovf beat%0d operands", issued), ops_now, bd(issued));
        checkOutput($sformatf("ovf beat%0d acc_clr", issued), 32'(acc_clr),
                    32'(issued == 1 || issued == 65));
        checkOutput($sformatf("ovf beat%0d beat_cnt", issued), 32'(beat_cnt),
                    32'((issued <= 64) ? issued : issued - 64));
      end
      if (err_ovf) begin
        ovf_seen++;
        ovf_cyc = cyc;
        checkOutput("err_ovf on beat 64", 32'(issued), 32'(64));
      end
      if (res_valid) begin
        res_seen++;
        if (res_seen == 1) checkOutput("res_valid after err_ovf", 32'(cyc - ovf_cyc), 32'(3));
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    checkOutput("err_ovf pulses", 32'(ovf_seen), 32'(1));
    checkOutput("res_valid pulses", 32'(res_seen), 32'(2));
    checkOutput("overflow beats issued", 32'(issued), 32'(65));

    // reset in the middle of a 6-beat vector
    $display("[TB] mid-vector reset sequence");
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1;
      in_data  = mk(8'(k), 8'h11, 8'h22, 8'(k));
      in_last  = 1'b0;
      tick();
    end
    checkOutput("pre-reset beat_cnt", 32'(beat_cnt), 32'(3));
    checkOutput("pre-reset operands", ops_now, mk(3, 8'h11, 8'h22, 3));
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst ebl",       32'(ebl),       32'(0));
    checkOutput("midrst operands",  ops_now,        32'(0));
    checkOutput("midrst beat_cnt",  32'(beat_cnt),  32'(0));
    checkOutput("midrst in_ready",  32'(in_ready),  32'(1));
    checkOutput("midrst busy",      32'(busy),      32'(0));
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput($sformatf("post-reset quiet%0d", k), 32'({res_valid, ebl}), 32'(0));
    end
    in_valid = 1'b1; in_data = mk(7, 7, 7, 7); in_last = 1'b0;
    tick();
    in_data = mk(8, 8, 8, 8); in_last = 1'b1;
    tick();
    checkOutput("restart ebl",      32'(ebl),      32'(1));
    checkOutput("restart acc_clr",  32'(acc_clr),  32'(1));
    checkOutput("restart beat_cnt", 32'(beat_cnt), 32'(1));
    checkOutput("restart operands", ops_now,       mk(7, 7, 7, 7));
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    checkOutput("restart last acc_clr",  32'(acc_clr),  32'(0));
    checkOutput("restart last beat_cnt", 32'(beat_cnt), 32'(2));
    wait_res("restart res_valid delay", 3);
    tick();
    checkOutput("restart final beat_cnt", 32'(beat_cnt), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
